// File: rtl/npu_mac_seq_if.sv
// npu_mac_seq_if: command, operand stream, MAC and result signals of the MAC sequencer
interface npu_mac_seq_if #(
    parameter int I_LEN = 8,
    parameter int O_LEN = 8,
    parameter int K_W   = 8
);
    logic             start_i;
    logic [K_W-1:0]   len_i;
    logic [K_W-1:0]   num_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             in_v_i;
    logic             in_rdy_o;
    logic [I_LEN-1:0] in_t0_i;
    logic [I_LEN-1:0] in_t1_i;
    logic             mac_clear_o;
    logic             mac_t0_v_o;
    logic [I_LEN-1:0] mac_t0_o;
    logic             mac_t1_v_o;
    logic [I_LEN-1:0] mac_t1_o;
    logic             mac_t2_v_i;
    logic [O_LEN-1:0] mac_t2_i;
    logic             res_v_o;
    logic             res_rdy_i;
    logic [O_LEN-1:0] res_o;

    modport master (
        input  start_i, len_i, num_i, in_v_i, in_t0_i, in_t1_i, mac_t2_v_i, mac_t2_i, res_rdy_i,
        output busy_o, done_o, err_o, in_rdy_o, mac_clear_o, mac_t0_v_o, mac_t0_o,
               mac_t1_v_o, mac_t1_o, res_v_o, res_o
    );
    modport slave (
        output start_i, len_i, num_i, in_v_i, in_t0_i, in_t1_i, mac_t2_v_i, mac_t2_i, res_rdy_i,
        input  busy_o, done_o, err_o, in_rdy_o, mac_clear_o, mac_t0_v_o, mac_t0_o,
               mac_t1_v_o, mac_t1_o, res_v_o, res_o
    );
endinterface

// File: rtl/npu_mac_seq.sv
// npu_mac_seq: streams operand pairs into one MAC, captures each dot product and hands it downstream
module npu_mac_seq #(
    parameter int I_LEN   = 8,
    parameter int O_LEN   = 8,
    parameter int K_W     = 8,
    parameter int RES_LAT = 1
) (
    input logic           clk_i,
    input logic           arstn_i,
    npu_mac_seq_if.master bus
);
    localparam int LW = (RES_LAT > 1) ? $clog2(RES_LAT + 1) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, OUT} state_t;

    state_t           state, nxt;
    logic [K_W-1:0]   len_q, num_q, cnt, dot;
    logic [LW-1:0]    lat;
    logic [O_LEN-1:0] res_q;
    logic             err_q, done_q;
    logic             go, zero_go, accept, last_pair, last_dot, hs;

    assign go        = state == IDLE && bus.start_i && bus.len_i != '0 && bus.num_i != '0;
    assign zero_go   = state == IDLE && bus.start_i && (bus.len_i == '0 || bus.num_i == '0);
    assign accept    = state == FEED && bus.in_v_i;
    assign last_pair = cnt == len_q - K_W'(1);
    assign last_dot  = dot == num_q - K_W'(1);
    assign hs        = state == OUT && bus.res_rdy_i;

    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.in_rdy_o    = state == FEED;
    assign bus.mac_clear_o = state == CLEAR;
    assign bus.mac_t0_v_o  = accept;
    assign bus.mac_t1_v_o  = accept;
    assign bus.mac_t0_o    = bus.in_t0_i;
    assign bus.mac_t1_o    = bus.in_t1_i;
    assign bus.res_v_o     = state == OUT;
    assign bus.res_o       = res_q;

    always_ff @(posedge clk_i or negedge arstn_i)
        if (!arstn_i) state <= IDLE;
        else          state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? CLEAR : IDLE;
            CLEAR:   nxt = FEED;
            FEED:    nxt = (accept && last_pair) ? WAIT : FEED;
            WAIT:    nxt = (lat == LW'(1)) ? OUT : WAIT;
            OUT:     nxt = hs ? (last_dot ? IDLE : CLEAR) : OUT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            len_q  <= '0;
            num_q  <= '0;
            cnt    <= '0;
            dot    <= '0;
            lat    <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= zero_go || (hs && last_dot);
            if (go) begin
                len_q <= bus.len_i;
                num_q <= bus.num_i;
                dot   <= '0;
                err_q <= 1'b0;
            end
            if (state == CLEAR) cnt <= '0;
            if (accept) begin
                cnt <= cnt + K_W'(1);
                if (last_pair) lat <= LW'(RES_LAT);
            end
            // Capture on the final WAIT edge; a missing MAC valid there is recorded, not retried
            if (state == WAIT) begin
                lat <= lat - LW'(1);
                if (lat == LW'(1)) begin
                    res_q <= bus.mac_t2_i;
                    if (!bus.mac_t2_v_i) err_q <= 1'b1;
                end
            end
            if (hs) dot <= dot + K_W'(1);
        end
    end
endmodule
